// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the KGP-miniRISC instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W      = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid register: catches the ROM word that lands while decode is stalled.
module fetch_hold_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               flush,
  input  logic               drain,
  input  logic [INSTR_W-1:0] din,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               valid,
  output logic [INSTR_W-1:0] dout,
  output logic [ADDR_W-1:0]  pc
);

  // Flush wins over capture so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      dout  <= din;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous ROM and feeds decode,
// with stall skid, branch/jump redirect and halt.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc;   // next word to request from the ROM
  logic [ADDR_W-1:0]  rd_pc;      // address of the read landing this cycle
  logic               rd_valid;   // imem_rdata carries a live (unsquashed) word
  logic               take_halt, take_redirect, stalled, advance;

  logic               hold_valid, hold_cap, hold_flush, hold_drain;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  logic               issue_ok;
  logic [INSTR_W-1:0] issue_instr;
  logic [ADDR_W-1:0]  issue_pc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // The redirect target bypasses fetch_pc onto the ROM port so that its word
  // lands one cycle later and only a single bubble is seen by decode.
  always_comb begin
    state_d       = state_q;
    take_halt     = 1'b0;
    take_redirect = 1'b0;
    stalled       = 1'b0;
    imem_en       = 1'b0;
    imem_addr     = fetch_pc;
    if (state_q != HALTED) begin
      take_halt     = halt;
      take_redirect = redirect_valid && !halt;
      stalled       = stall && instr_valid && !redirect_valid && !halt;
      imem_en       = !stalled;
      if (take_redirect) imem_addr = redirect_pc;
      if (take_halt)               state_d = HALTED;
      else if (take_redirect)      state_d = FILL;
      else if (state_q == FILL)    state_d = RUN;
    end
  end

  assign halted  = (state_q == HALTED);
  assign advance = (state_q != HALTED) && !take_halt && !take_redirect && !stalled;

  assign hold_cap   = stalled && rd_valid;
  assign hold_flush = take_redirect || take_halt;
  assign hold_drain = advance && hold_valid;

  // A held word is always older than anything on the ROM port.
  assign issue_ok    = hold_valid || rd_valid;
  assign issue_instr = hold_valid ? hold_instr : imem_rdata;
  assign issue_pc    = hold_valid ? hold_pc    : rd_pc;

  fetch_hold_reg #(.ADDR_W(ADDR_W)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .capture (hold_cap),
    .flush   (hold_flush),
    .drain   (hold_drain),
    .din     (imem_rdata),
    .pc_in   (rd_pc),
    .valid   (hold_valid),
    .dout    (hold_instr),
    .pc      (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RST_PC;
      rd_pc       <= '0;
      rd_valid    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      pc_plus1    <= ONE;
    end else begin
      if (imem_en) begin
        fetch_pc <= imem_addr + ONE;
        rd_pc    <= imem_addr;
      end
      rd_valid <= imem_en && !take_halt;
      if (advance) begin
        instr_valid <= issue_ok;
        if (issue_ok) begin
          instr    <= issue_instr;
          pc_out   <= issue_pc;
          pc_plus1 <= issue_pc + ONE;
        end
      end else if (!stalled) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a stream-level reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        imem_en, instr_valid, halted;
  logic [9:0]  imem_addr, pc_out, pc_plus1;
  logic [31:0] imem_rdata = '0, instr;

  logic        w_rst = 1'b1, w_en, w_valid, w_halted;
  logic [3:0]  w_addr, w_pc, w_pc1;
  logic [31:0] w_rdata = '0, w_instr;

  int n_cmp = 0, n_bad = 0;

  // reference model: expected output stream, not pipeline internals
  logic       m_known = 1'b0, m_valid = 1'b0, m_halted = 1'b0, m_rstvals = 1'b0;
  logic [9:0] m_pc = '0, m_next = '0;
  int         m_bub = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(14)) dut_w (
    .clk(clk), .rst(w_rst), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(4'd0), .halt(1'b0), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr(w_instr), .instr_valid(w_valid),
    .pc_out(w_pc), .pc_plus1(w_pc1), .halted(w_halted)
  );

  // ROM contents: mem[i] = 0xA000_0000 + i
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'hA000_0000 + 32'(imem_addr);
    if (w_en)    w_rdata    <= 32'hA000_0000 + 32'(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [9:0] rp, input logic h);
    logic exp_en;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp; halt = h;
    #1;
    if (m_known) begin
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      if (m_valid) begin
        chk("pc_out", {22'd0, pc_out}, {22'd0, m_pc});
        chk("instr", instr, 32'hA000_0000 + 32'(m_pc));
        chk("pc_plus1", {22'd0, pc_plus1}, {22'd0, 10'(m_pc + 10'd1)});
      end else if (m_rstvals) begin
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", {22'd0, pc_out}, 32'd0);
        chk("rst_pc_plus1", {22'd0, pc_plus1}, 32'd1);
      end
      exp_en = !m_halted && !(s && m_valid && !rv && !h);
      chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_valid = 1'b0; m_halted = 1'b0; m_rstvals = 1'b1;
      m_next = 10'd0; m_bub = 1;
    end else if (m_known && !m_halted) begin
      if (h) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (rv) begin
        m_valid = 1'b0; m_next = rp; m_bub = 0;
      end else if (s && m_valid) begin
        // decode holds the current word
      end else if (m_bub > 0) begin
        m_bub--; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_next = m_next + 10'd1; m_rstvals = 1'b0;
      end
    end
  endtask

  task automatic run_until(input logic [9:0] target);
    int n = 0;
    while (!(m_valid && m_pc == target) && n < 64) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
      n++;
    end
    #1;
    chk("reach_pc", {22'd0, pc_out}, {22'd0, target});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  initial begin
    // reset and free run, then 3-cycle stall at pc 4
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    run_until(10'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    idle(3);
    // redirect at pc 7
    run_until(10'd7);
    step(1'b0, 1'b0, 1'b1, 10'h20, 1'b0);
    idle(3);
    // redirect together with stall at pc 3
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    run_until(10'd3);
    step(1'b0, 1'b1, 1'b1, 10'h10, 1'b0);
    idle(3);
    // halt plus redirect at pc 9, then restart with rst
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    run_until(10'd9);
    step(1'b0, 1'b0, 1'b1, 10'h30, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    idle(4);
    // rst while stalled with the skid entry full
    run_until(10'd5);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
    idle(4);
    // redirect to the top of memory to cover wrap
    step(1'b0, 1'b0, 1'b1, 10'h3FE, 1'b0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      logic       r, s, rv, h;
      logic [9:0] rp;
      r  = ($urandom_range(0, 59) == 0);
      h  = ($urandom_range(0, 69) == 0);
      rv = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 2) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
      step(r, s, rv, rp, h);
    end

    // ADDR_W=4, RESET_PC=14 instance: wrap 14,15,0,1
    @(negedge clk); w_rst = 1'b1;
    @(negedge clk); w_rst = 1'b0;
    @(negedge clk);
    chk("w_valid_fill", {31'd0, w_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("w_valid", {31'd0, w_valid}, 32'd1);
      chk("w_pc", {28'd0, w_pc}, 32'((14 + k) % 16));
      chk("w_pc1", {28'd0, w_pc1}, 32'((15 + k) % 16));
      chk("w_instr", w_instr, 32'hA000_0000 + 32'((14 + k) % 16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
